// File: rtl/avalon_mm_host_bridge.sv
// Avalon-MM host bridge: a valid/ready request stream becomes pipelined Avalon-MM commands.
// Responses come back in order and are checked against a FIFO of the command types.
module avalon_mm_host_bridge #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic                                         req_is_wr,
  input  logic [ADDR_WIDTH-1:0]                        req_addr,
  input  logic [DATA_WIDTH-1:0]                        req_wr_data,
  input  logic [DATA_WIDTH/8-1:0]                      req_wr_strb,
  output logic                                         rsp_valid,
  output logic                                         rsp_is_wr,
  output logic [DATA_WIDTH-1:0]                        rsp_data,
  output logic                                         rsp_err,
  output logic                                         protocol_err,
  output logic                                         avm_read,
  output logic                                         avm_write,
  input  logic                                         avm_waitrequest,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]   avm_address,
  output logic [DATA_WIDTH-1:0]                        avm_writedata,
  output logic [DATA_WIDTH/8-1:0]                      avm_byteenable,
  input  logic                                         avm_readdatavalid,
  input  logic                                         avm_writeresponsevalid,
  input  logic [DATA_WIDTH-1:0]                        avm_readdata,
  input  logic [1:0]                                   avm_response
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BE_W);
  localparam int AW    = ADDR_WIDTH - OFS;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic             r_rd;
  logic             r_wr;
  logic [AW-1:0]    r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BE_W-1:0]  r_be;

  logic             r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;

  logic             r_rsp_valid;
  logic             r_rsp_is_wr;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;
  logic             r_perr;

  logic             w_pending;
  logic             w_cmd_accept;
  logic             w_req_hs;
  logic [CNT_W:0]   w_inflight;
  logic             w_head;
  logic             w_fifo_empty;
  logic             w_rsp_any;
  logic             w_rsp_ok;
  logic             w_viol;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign w_pending    = r_rd | r_wr;
  assign w_cmd_accept = w_pending & ~avm_waitrequest;
  assign w_inflight   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, w_pending};
  // Count the pending command too, so an accept can never overflow the order FIFO.
  assign req_ready    = (~w_pending | ~avm_waitrequest) &
                        (w_inflight < (CNT_W+1)'(MAX_OUTSTANDING));
  assign w_req_hs     = req_valid & req_ready;

  assign w_head       = r_fifo[r_rptr];
  assign w_fifo_empty = (r_cnt == '0);
  assign w_rsp_any    = avm_readdatavalid | avm_writeresponsevalid;
  assign w_rsp_ok     = w_rsp_any & ~(avm_readdatavalid & avm_writeresponsevalid) &
                        ~w_fifo_empty & (w_head == avm_writeresponsevalid);
  assign w_viol       = w_rsp_any & ~w_rsp_ok;

  generate
    if (OFS > 0) begin : g_unused_lsb
      logic w_unused_addr_lsb;
      assign w_unused_addr_lsb = ^req_addr[OFS-1:0];
    end
  endgenerate

  // Command register: reloads on handshake, clears once the agent takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_req_hs) begin
      r_rd    <= ~req_is_wr;
      r_wr    <= req_is_wr;
      r_addr  <= req_addr[ADDR_WIDTH-1:OFS];
      r_wdata <= req_wr_data;
      r_be    <= req_is_wr ? req_wr_strb : {BE_W{1'b1}};
    end else if (w_cmd_accept) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end
  end

  // Order FIFO of command types, pushed on Avalon accept, popped on a valid response.
  always_ff @(posedge clk) begin
    if (w_cmd_accept) r_fifo[r_wptr] <= r_wr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_cmd_accept) r_wptr <= next_ptr(r_wptr);
      if (w_rsp_ok)     r_rptr <= next_ptr(r_rptr);
      case ({w_cmd_accept, w_rsp_ok})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Response stage: one cycle after the agent's valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_is_wr <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_perr      <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_ok;
      if (w_rsp_ok) begin
        r_rsp_is_wr <= w_head;
        r_rsp_data  <= w_head ? '0 : avm_readdata;
        r_rsp_err   <= |avm_response;
      end
      if (w_viol) r_perr <= 1'b1;
    end
  end

  assign avm_read       = r_rd;
  assign avm_write      = r_wr;
  assign avm_address    = r_addr;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = r_be;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_is_wr      = r_rsp_is_wr;
  assign rsp_data       = r_rsp_data;
  assign rsp_err        = r_rsp_err;
  assign protocol_err   = r_perr;

endmodule

// File: tb/tb_avalon_mm_host_bridge.sv
// Bench for avalon_mm_host_bridge: directed scenarios then random traffic,
// all checked against a queue-based transaction model of the bridge.
module tb_avalon_mm_host_bridge;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wr_data = '0;
  logic [3:0]  req_wr_strb = '0;
  logic        rsp_valid;
  logic        rsp_is_wr;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        protocol_err;
  logic        avm_read;
  logic        avm_write;
  logic        avm_waitrequest = 1'b0;
  logic [29:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_writeresponsevalid = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic [1:0]  avm_response = '0;

  int n_asrt = 0;
  int n_fail = 0;

  // Transaction model: one optional command waiting for the agent, a queue
  // of accepted command types, and the response expected after each edge.
  bit          m_out[$];
  bit          m_pend;
  bit          m_cmd_wr;
  logic [29:0] m_cmd_addr;
  logic [31:0] m_cmd_data;
  logic [3:0]  m_cmd_be;
  bit          m_rsp_v;
  bit          m_rsp_wr;
  bit          m_rsp_err;
  logic [31:0] m_rsp_data;
  bit          m_perr;

  avalon_mm_host_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_wr(req_is_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_wr_strb(req_wr_strb),
    .rsp_valid(rsp_valid), .rsp_is_wr(rsp_is_wr), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .protocol_err(protocol_err),
    .avm_read(avm_read), .avm_write(avm_write), .avm_waitrequest(avm_waitrequest),
    .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdatavalid(avm_readdatavalid), .avm_writeresponsevalid(avm_writeresponsevalid),
    .avm_readdata(avm_readdata), .avm_response(avm_response)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    req_valid = 1'b0; req_is_wr = 1'b0; req_addr = '0; req_wr_data = '0; req_wr_strb = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_writeresponsevalid = 1'b0;
    avm_readdata = '0; avm_response = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_avm_read",   64'(avm_read), 64'(0));
    chk("rst_avm_write",  64'(avm_write), 64'(0));
    chk("rst_avm_addr",   64'(avm_address), 64'(0));
    chk("rst_avm_wdata",  64'(avm_writedata), 64'(0));
    chk("rst_avm_be",     64'(avm_byteenable), 64'(0));
    chk("rst_rsp_valid",  64'(rsp_valid), 64'(0));
    chk("rst_rsp_is_wr",  64'(rsp_is_wr), 64'(0));
    chk("rst_rsp_data",   64'(rsp_data), 64'(0));
    chk("rst_rsp_err",    64'(rsp_err), 64'(0));
    chk("rst_perr",       64'(protocol_err), 64'(0));
    chk("rst_req_ready",  64'(req_ready), 64'(1));
    rst_n = 1'b1;
    m_out.delete();
    m_pend = 0; m_rsp_v = 0; m_perr = 0;
  endtask

  // One clock: apply inputs, check req_ready, advance the model, check registered outputs.
  task automatic step(input bit rv, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit wq, input bit rdv, input bit wrv,
                      input logic [31:0] rdat, input logic [1:0] resp);
    bit exp_ready;
    req_valid = rv; req_is_wr = wr; req_addr = a; req_wr_data = d; req_wr_strb = s;
    avm_waitrequest = wq; avm_readdatavalid = rdv; avm_writeresponsevalid = wrv;
    avm_readdata = rdat; avm_response = resp;
    #1;
    exp_ready = (!m_pend || !wq) && ((m_out.size() + int'(m_pend)) < MAXO);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    m_rsp_v = 0;
    if (rdv || wrv) begin
      if ((rdv && wrv) || m_out.size() == 0 || m_out[0] != wrv) m_perr = 1;
      else begin
        m_rsp_v = 1; m_rsp_wr = wrv; m_rsp_err = (resp != 2'b00);
        m_rsp_data = wrv ? 32'h0 : rdat;
        void'(m_out.pop_front());
      end
    end
    if (m_pend && !wq) begin
      m_out.push_back(m_cmd_wr);
      m_pend = 0;
    end
    if (rv && exp_ready) begin
      m_pend = 1; m_cmd_wr = wr; m_cmd_addr = a[31:2]; m_cmd_data = d;
      m_cmd_be = wr ? s : 4'hF;
    end
    @(posedge clk); #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
    if (m_rsp_v) begin
      chk("rsp_is_wr", 64'(rsp_is_wr), 64'(m_rsp_wr));
      chk("rsp_data",  64'(rsp_data),  64'(m_rsp_data));
      chk("rsp_err",   64'(rsp_err),   64'(m_rsp_err));
    end
    chk("protocol_err", 64'(protocol_err), 64'(m_perr));
    chk("avm_read",  64'(avm_read),  64'(m_pend && !m_cmd_wr));
    chk("avm_write", 64'(avm_write), 64'(m_pend && m_cmd_wr));
    if (m_pend) begin
      chk("avm_address",    64'(avm_address),    64'(m_cmd_addr));
      chk("avm_writedata",  64'(avm_writedata),  64'(m_cmd_data));
      chk("avm_byteenable", 64'(avm_byteenable), 64'(m_cmd_be));
    end
  endtask

  task automatic idle(input bit wq);
    step(0, 0, 32'h0, 32'h0, 4'h0, wq, 0, 0, 32'h0, 2'b00);
  endtask

  task automatic rd_req(input logic [31:0] a);
    step(1, 0, a, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00);
  endtask

  task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    step(1, 1, a, d, s, 0, 0, 0, 32'h0, 2'b00);
  endtask

  task automatic rd_rsp(input logic [31:0] rdat, input logic [1:0] resp);
    step(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, rdat, resp);
  endtask

  task automatic wr_rsp(input logic [1:0] resp);
    step(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 1, 32'h0, resp);
  endtask

  initial begin
    bit          rv, wr, wq, rdv, wrv;
    logic [31:0] a, d, rdat;
    logic [3:0]  s;
    logic [1:0]  resp;

    drive_idle();
    do_reset();

    // Single read
    rd_req(32'h0000_0010);
    chk("sr_read",  64'(avm_read), 64'(1));
    chk("sr_addr",  64'(avm_address), 64'(30'h4));
    chk("sr_be",    64'(avm_byteenable), 64'(4'hF));
    idle(0);
    chk("sr_read_drop", 64'(avm_read), 64'(0));
    rd_rsp(32'hDEAD_BEEF, 2'b00);
    chk("sr_rsp_data", 64'(rsp_data), 64'(32'hDEAD_BEEF));
    chk("sr_rsp_wr",   64'(rsp_is_wr), 64'(0));

    // Write held by waitrequest for three cycles
    wr_req(32'h8, 32'h1234_5678, 4'h3);
    chk("ws_addr", 64'(avm_address), 64'(30'h2));
    chk("ws_be",   64'(avm_byteenable), 64'(4'h3));
    repeat (3) begin
      step(1, 0, 32'h40, 32'h0, 4'h0, 1, 0, 0, 32'h0, 2'b00);
      chk("ws_hold_write", 64'(avm_write), 64'(1));
      chk("ws_hold_data",  64'(avm_writedata), 64'(32'h1234_5678));
    end
    idle(0);
    wr_rsp(2'b10);
    chk("ws_rsp_wr",  64'(rsp_is_wr), 64'(1));
    chk("ws_rsp_err", 64'(rsp_err), 64'(1));

    // Four reads fill the window; the write waits for the first response
    for (int i = 0; i < 4; i++) rd_req(32'h100 + 32'(i * 4));
    step(1, 1, 32'h200, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 32'h0, 2'b00);
    step(1, 1, 32'h200, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 32'h0, 2'b00);
    chk("bb_full_ready", 64'(req_ready), 64'(0));
    step(1, 1, 32'h200, 32'hCAFE_F00D, 4'hC, 0, 1, 0, 32'h1111_0000, 2'b00);
    chk("bb_ready_after_rsp", 64'(req_ready), 64'(1));
    step(1, 1, 32'h200, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 32'h0, 2'b00);
    chk("bb_write_issued", 64'(avm_write), 64'(1));
    idle(0);
    for (int i = 1; i < 4; i++) rd_rsp(32'h1111_0000 + 32'(i), 2'b00);
    wr_rsp(2'b00);

    // Mixed R, W, R returned in order
    rd_req(32'h20);
    wr_req(32'h24, 32'hA5A5_5A5A, 4'hF);
    rd_req(32'h28);
    idle(0);
    rd_rsp(32'h0000_00AA, 2'b00);
    chk("mx_rsp0_wr", 64'(rsp_is_wr), 64'(0));
    wr_rsp(2'b00);
    chk("mx_rsp1_wr", 64'(rsp_is_wr), 64'(1));
    rd_rsp(32'h0000_00BB, 2'b01);
    chk("mx_rsp2_wr", 64'(rsp_is_wr), 64'(0));

    // Protocol violations
    wr_rsp(2'b00);
    chk("pv_empty_perr", 64'(protocol_err), 64'(1));
    chk("pv_empty_norsp", 64'(rsp_valid), 64'(0));
    do_reset();
    rd_req(32'h30);
    idle(0);
    step(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 1, 32'h5, 2'b00);
    chk("pv_both_perr", 64'(protocol_err), 64'(1));
    wr_rsp(2'b00);
    rd_rsp(32'h6, 2'b00);
    do_reset();

    // Reset with two reads in flight
    rd_req(32'h40);
    rd_req(32'h44);
    idle(0);
    do_reset();
    rd_rsp(32'h7, 2'b00);
    chk("rm_late_perr", 64'(protocol_err), 64'(1));
    do_reset();

    // Random traffic with a well-behaved agent
    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(0, 99) < 60);
      wr = ($urandom_range(0, 1) == 1);
      a = $urandom; d = $urandom; s = 4'($urandom); rdat = $urandom;
      resp = 2'($urandom);
      wq = ($urandom_range(0, 99) < 30);
      rdv = 0; wrv = 0;
      if (m_out.size() > 0 && $urandom_range(0, 99) < 45) begin
        if (m_out[0]) wrv = 1; else rdv = 1;
      end
      step(rv, wr, a, d, s, wq, rdv, wrv, rdat, resp);
    end
    for (int k = 0; k < 20 && (m_out.size() > 0 || m_pend); k++) begin
      if (m_out.size() > 0) begin
        if (m_out[0]) wr_rsp(2'b00); else rd_rsp($urandom, 2'b00);
      end else idle(0);
    end
    chk("drain_outstanding", 64'(m_out.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_mm_host_bridge.md
Name: avalon_mm_host_bridge

Overview:
- Avalon-MM host-side bridge: turns a simple valid/ready request stream from an internal requester (test sequencer, DMA or bus adapter) into pipelined Avalon-MM host commands, and returns in-order read/write responses.
- Sits opposite the generated register-block agent, so the team can drive regblocks from internal logic without an external Avalon master.
- Tracks up to MAX_OUTSTANDING commands and flags protocol violations.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; power of 2, ≥8.
- ADDR_WIDTH, 32, byte address width on the request side.
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered Avalon commands; power of 2, ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  bridge accepts request this cycle
- req_is_wr  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  byte address
- req_wr_data  in  DATA_WIDTH  write data
- req_wr_strb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  one-cycle response pulse (no backpressure)
- rsp_is_wr  out  1  response type
- rsp_data  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  avm_response != 0
- protocol_err  out  1  sticky violation flag
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_waitrequest  in  1  agent stall
- avm_address  out  ADDR_WIDTH-log2(DATA_WIDTH/8)  word address
- avm_writedata  out  DATA_WIDTH
- avm_byteenable  out  DATA_WIDTH/8
- avm_readdatavalid  in  1
- avm_writeresponsevalid  in  1
- avm_readdata  in  DATA_WIDTH
- avm_response  in  2

Behaviour:
- Reset: one clock, clk. Reset is synchronous and active-low on rst_n. While reset is asserted, all registered outputs go to 0: avm_read, avm_write, avm_address, avm_writedata, avm_byteenable, rsp_*, protocol_err. The outstanding counter and order FIFO clear. A reset mid-transaction discards all in-flight state; late Avalon responses arriving after reset count as unexpected.
- Command register:
  - Holds at most one pending command.
  - Request handshake = req_valid & req_ready. On handshake, the next cycle drives avm_read = ~req_is_wr or avm_write = req_is_wr.
  - avm_address = req_addr >> log2(DATA_WIDTH/8); the low address bits are dropped.
  - avm_byteenable = req_wr_strb for writes, all-ones for reads.
  - avm_writedata = req_wr_data.
- Avalon accept: cmd_accept = (avm_read | avm_write) & ~avm_waitrequest. All avm_* command outputs hold stable while waitrequest is high.
- req_ready = (~cmd_pending | ~avm_waitrequest) & (outstanding + cmd_pending < MAX_OUTSTANDING). This is combinational on avm_waitrequest. It gives back-to-back throughput of 1 command/cycle when waitrequest stays low.
  - If a handshake and cmd_accept occur in the same cycle, the new command replaces the old one in the next cycle with no bubble.
  - If no handshake occurs, read and write are deasserted next cycle.
- Order FIFO:
  - Depth MAX_OUTSTANDING, 1 bit wide (is_wr).
  - Push on cmd_accept; pop on any accepted response.
  - Outstanding counter width log2(MAX_OUTSTANDING)+1. Push and pop in the same cycle leave it unchanged.
- Response path (registered, 1-cycle latency):
  - avm_readdatavalid with FIFO head = read, or avm_writeresponsevalid with head = write, gives rsp_valid=1 next cycle.
  - rsp_is_wr = head; rsp_data = readdata for reads, 0 for writes; rsp_err = |avm_response.
- Protocol errors: set protocol_err (cleared only by reset) and drop the response, with no pop and no rsp_valid, when any of the following occurs:
  - A response arrives while the FIFO is empty.
  - The response type mismatches the FIFO head.
  - avm_readdatavalid and avm_writeresponsevalid are both high.
- Responses are strictly in command order.

Test Plan:
- Single read: req addr=0x0000_0010, waitrequest=0. Required: avm_read=1 with avm_address=0x4 for 1 cycle, byteenable=0xF. Agent returns readdata=0xDEADBEEF, response=0 → rsp_valid, rsp_is_wr=0, rsp_data=0xDEADBEEF, rsp_err=0.
- Write with stall: req write addr=0x8, data=0x1234_5678, strb=0x3. Hold waitrequest=1 for 3 cycles. Required: avm_write, address=0x2, writedata and byteenable=0x3 stable for 4 cycles, req_ready=0 during stall. writeresponsevalid with response=2'b10 → rsp_is_wr=1, rsp_err=1.
- Back-to-back: 4 reads then 1 write, waitrequest=0, no responses returned. Required: 4 consecutive avm_read cycles, then req_ready=0. After the first readdatavalid, req_ready=1 and the write issues.
- Mixed order: issue R,W,R. Return readdatavalid, writeresponsevalid, readdatavalid. Required: rsp sequence is_wr = 0,1,0, each one cycle after its response.
- Violations: writeresponsevalid with FIFO empty → protocol_err=1, no rsp_valid. After reset, protocol_err=0. Then both valids high on the same cycle → protocol_err=1.
- Reset mid-flight: 2 reads outstanding, assert rst_n=0 for 1 cycle. Required: avm_read=0, req_ready=1 after reset. A late readdatavalid sets protocol_err.
